// File: rtl/status_pkg.sv
// Shared constants for the rstatus exception/status register.
// Opcode, ALU-op and status-code values, plus the datapath widths.
package status_pkg;

    localparam int W_STATUS = 27;
    localparam int W_OP     = 5;

    typedef enum logic [W_OP-1:0] {
        OP_RTYPE = 5'd0,
        OP_ADDI  = 5'd5,
        OP_SETX  = 5'd21
    } opcode_e;

    typedef enum logic [W_OP-1:0] {
        ALU_ADD = 5'd0,
        ALU_SUB = 5'd1,
        ALU_MUL = 5'd6,
        ALU_DIV = 5'd7
    } alu_e;

    localparam logic [W_STATUS-1:0] ST_ADD  = W_STATUS'(1);
    localparam logic [W_STATUS-1:0] ST_ADDI = W_STATUS'(2);
    localparam logic [W_STATUS-1:0] ST_SUB  = W_STATUS'(3);
    localparam logic [W_STATUS-1:0] ST_MUL  = W_STATUS'(4);
    localparam logic [W_STATUS-1:0] ST_DIV  = W_STATUS'(5);

endpackage

// File: rtl/status_decode.sv
// Next-value and load-enable decode for the status register.
// Macro STATUS_MULDIV_EN adds MUL/DIV overflow codes below SUB.
module status_decode
    import status_pkg::*;
(
    input  logic [W_OP-1:0]     opcode_i,
    input  logic [W_OP-1:0]     alu_code_i,
    input  logic [W_STATUS-1:0] target_i,
    input  logic                overflow_i,
    output logic                load_en_o,
    output logic [W_STATUS-1:0] status_d_o
);

    always_comb begin
        // NOTE: defaults first so every path assigns both outputs; no latch can be inferred.
        load_en_o  = 1'b0;
        status_d_o = target_i;

        // SETX wins over any overflow report in the same cycle.
        if (opcode_i == OP_SETX) begin
            load_en_o  = 1'b1;
            status_d_o = target_i;
        end else if (overflow_i) begin
            if (opcode_i == OP_RTYPE) begin
                case (alu_code_i)
                    ALU_ADD: begin load_en_o = 1'b1; status_d_o = ST_ADD; end
                    ALU_SUB: begin load_en_o = 1'b1; status_d_o = ST_SUB; end
`ifdef STATUS_MULDIV_EN
                    ALU_MUL: begin load_en_o = 1'b1; status_d_o = ST_MUL; end
                    ALU_DIV: begin load_en_o = 1'b1; status_d_o = ST_DIV; end
`endif
                    default: begin load_en_o = 1'b0; status_d_o = target_i; end
                endcase
            end else if (opcode_i == OP_ADDI) begin
                load_en_o  = 1'b1;
                status_d_o = ST_ADDI;
            end
        end
    end

endmodule

// File: rtl/status_reg.sv
// rstatus register: synchronous-reset enable register around status_decode.
// Macro STATUS_MULDIV_EN (handled in status_decode) enables MUL/DIV codes.
module status_reg
    import status_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [W_OP-1:0]     opcode,
    input  logic [W_OP-1:0]     alu_code,
    input  logic [W_STATUS-1:0] target,
    input  logic                overflow,
    output logic [W_STATUS-1:0] status_out
);

    logic                load_en;
    logic [W_STATUS-1:0] status_d;
    logic [W_STATUS-1:0] status_q;

    status_decode u_decode (
        .opcode_i   (opcode),
        .alu_code_i (alu_code),
        .target_i   (target),
        .overflow_i (overflow),
        .load_en_o  (load_en),
        .status_d_o (status_d)
    );

    // NOTE: reset is synchronous here, so it lives inside the clocked block, not the sensitivity list.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: non-blocking assignments for all registered state.
            status_q <= '0;
        end else if (load_en) begin
            status_q <= status_d;
        end
    end

    assign status_out = status_q;

endmodule

// File: tb/tb_status_reg.sv
// Self-checking bench for status_reg: directed vector table, opcode/alu sweep
// and randomized stimulus against a rule-level reference model.
module tb_status_reg;

    logic        clock;
    logic        reset;
    logic [4:0]  opcode;
    logic [4:0]  alu_code;
    logic [26:0] target;
    logic        overflow;
    logic [26:0] status_out;

    int total = 0;
    int bad   = 0;

    logic [26:0] model_q;
    int          rtype_code [32];

    typedef struct {
        logic        rst;
        logic [4:0]  op;
        logic [4:0]  alu;
        logic [26:0] tgt;
        logic        ov;
        logic [26:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[$];

    status_reg dut (
        .clock      (clock),
        .reset      (reset),
        .opcode     (opcode),
        .alu_code   (alu_code),
        .target     (target),
        .overflow   (overflow),
        .status_out (status_out)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [26:0] actual, input logic [26:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference: exception code per R-type alu_code (0 = no exception), plus the opcode rules.
    function automatic logic [26:0] model_next(input logic [26:0] cur, input logic rst,
                                               input logic [4:0] op, input logic [4:0] alu,
                                               input logic [26:0] tgt, input logic ov);
        if (rst) return 27'd0;
        if (op == 5'd21) return tgt;
        if (!ov) return cur;
        if (op == 5'd5) return 27'd2;
        if (op == 5'd0 && rtype_code[alu] != 0) return 27'(rtype_code[alu]);
        return cur;
    endfunction

    task automatic drive_and_check(input string name, input logic rst, input logic [4:0] op,
                                   input logic [4:0] alu, input logic [26:0] tgt, input logic ov);
        logic [26:0] expv;
        expv     = model_next(model_q, rst, op, alu, tgt, ov);
        reset    = rst;
        opcode   = op;
        alu_code = alu;
        target   = tgt;
        overflow = ov;
        @(posedge clock);
        #1;
        check(name, status_out, expv);
        model_q  = expv;
    endtask

    initial begin
        for (int i = 0; i < 32; i++) rtype_code[i] = 0;
        rtype_code[0] = 1;
        rtype_code[1] = 3;
`ifdef STATUS_MULDIV_EN
        rtype_code[6] = 4;
        rtype_code[7] = 5;
`endif

        vecs.push_back('{rst:1'b1, op:5'd21, alu:5'd0, tgt:27'd241, ov:1'b0, exp:27'd0,   name:"reset_c1"});
        vecs.push_back('{rst:1'b1, op:5'd21, alu:5'd0, tgt:27'd241, ov:1'b1, exp:27'd0,   name:"reset_c2"});
        vecs.push_back('{rst:1'b0, op:5'd21, alu:5'd0, tgt:27'd241, ov:1'b1, exp:27'd241, name:"setx_ov1"});
        vecs.push_back('{rst:1'b0, op:5'd21, alu:5'd3, tgt:27'd1234, ov:1'b0, exp:27'd1234, name:"setx_ov0"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd0, tgt:27'd99,  ov:1'b1, exp:27'd1,   name:"add_ovf"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd1, tgt:27'd99,  ov:1'b1, exp:27'd3,   name:"sub_ovf"});
        vecs.push_back('{rst:1'b0, op:5'd5,  alu:5'd9, tgt:27'd99,  ov:1'b1, exp:27'd2,   name:"addi_ovf"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd1, tgt:27'd99,  ov:1'b1, exp:27'd3,   name:"sub_again"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd2, tgt:27'd99,  ov:1'b1, exp:27'd3,   name:"and_ovf_hold"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd0, tgt:27'd99,  ov:1'b0, exp:27'd3,   name:"add_noovf_hold"});
        vecs.push_back('{rst:1'b0, op:5'd5,  alu:5'd0, tgt:27'd99,  ov:1'b0, exp:27'd3,   name:"addi_noovf_hold"});
`ifdef STATUS_MULDIV_EN
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd6, tgt:27'd99,  ov:1'b1, exp:27'd4,   name:"mul_ovf"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd7, tgt:27'd99,  ov:1'b1, exp:27'd5,   name:"div_ovf"});
`else
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd6, tgt:27'd99,  ov:1'b1, exp:27'd3,   name:"mul_ovf_hold"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd7, tgt:27'd99,  ov:1'b1, exp:27'd3,   name:"div_ovf_hold"});
`endif
        vecs.push_back('{rst:1'b0, op:5'd21, alu:5'd0, tgt:27'h7FFFFFF, ov:1'b1, exp:27'h7FFFFFF, name:"setx_max"});
        vecs.push_back('{rst:1'b0, op:5'd10, alu:5'd0, tgt:27'd5,   ov:1'b1, exp:27'h7FFFFFF, name:"op10_hold"});
        vecs.push_back('{rst:1'b0, op:5'd31, alu:5'd1, tgt:27'd5,   ov:1'b1, exp:27'h7FFFFFF, name:"op31_hold"});
        vecs.push_back('{rst:1'b1, op:5'd0,  alu:5'd0, tgt:27'd5,   ov:1'b1, exp:27'd0,   name:"reset_over_add"});
        vecs.push_back('{rst:1'b0, op:5'd0,  alu:5'd0, tgt:27'd5,   ov:1'b1, exp:27'd1,   name:"add_after_reset"});

        reset    = 1'b1;
        opcode   = 5'd0;
        alu_code = 5'd0;
        target   = 27'd0;
        overflow = 1'b0;
        model_q  = 27'd0;

        foreach (vecs[i]) begin
            reset    = vecs[i].rst;
            opcode   = vecs[i].op;
            alu_code = vecs[i].alu;
            target   = vecs[i].tgt;
            overflow = vecs[i].ov;
            @(posedge clock);
            #1;
            check(vecs[i].name, status_out, vecs[i].exp);
            model_q = vecs[i].exp;
        end

        // Reset arriving in the middle of a SETX / overflow burst.
        drive_and_check("seq_setx", 1'b0, 5'd21, 5'd0, 27'd777, 1'b0);
        drive_and_check("seq_rst_mid", 1'b1, 5'd21, 5'd0, 27'd888, 1'b1);
        drive_and_check("seq_addi_post", 1'b0, 5'd5, 5'd0, 27'd888, 1'b1);

        // Sweep alu_code with overflow toggling every cycle for several opcodes.
        begin
            logic [4:0] sweep_ops [4];
            logic       ov_t;
            sweep_ops[0] = 5'd0;
            sweep_ops[1] = 5'd21;
            sweep_ops[2] = 5'd21 + 5'd21;
            sweep_ops[3] = 5'd31;
            ov_t = 1'b0;
            foreach (sweep_ops[k]) begin
                for (int a = 0; a < 32; a++) begin
                    ov_t = ~ov_t;
                    drive_and_check($sformatf("sweep_op%0d_alu%0d", sweep_ops[k], a),
                                    1'b0, sweep_ops[k], 5'(a), 27'($urandom()), ov_t);
                end
                ov_t = ~ov_t;
            end
        end

        // Randomized traffic biased toward the interesting opcodes.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] op_r;
            logic [4:0] alu_r;
            case ($urandom_range(0, 5))
                0, 1:    op_r = 5'd0;
                2:       op_r = 5'd5;
                3:       op_r = 5'd21;
                default: op_r = 5'($urandom());
            endcase
            alu_r = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 7)) : 5'($urandom());
            drive_and_check($sformatf("rand_%0d", n), ($urandom_range(0, 29) == 0),
                            op_r, alu_r, 27'($urandom()), 1'($urandom()));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
